// File: rtl/mesh_router_xy.sv
// mesh_router_xy: single-flit 5-port mesh router with per-input FIFOs,
// dimension-order (X first, then Y) routing, per-output round-robin arbiters
// and registered valid/ready output stages. Port index: 0=W 1=E 2=N 3=S 4=PE.
// Flits whose route points back out of their arrival link are discarded and
// counted in a saturating 16-bit drop counter.
module mesh_router_xy #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int COORD_W    = 4,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4:0]              in_si,
    input  logic [5*DATA_WIDTH-1:0] in_di,
    output logic [4:0]              in_ri,
    output logic [4:0]              out_so,
    input  logic [4:0]              out_ro,
    output logic [5*DATA_WIDTH-1:0] out_do,
    output logic [15:0]             drop_count
);

    localparam int NP    = 5;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [COORD_W-1:0] MY_X_C   = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C   = COORD_W'(MY_Y);

    // XY route: resolve X first, then Y, otherwise deliver locally
    function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] dst_x,
                                            input logic [COORD_W-1:0] dst_y);
        if (dst_x > MY_X_C)      return 3'd1;
        else if (dst_x < MY_X_C) return 3'd0;
        else if (dst_y > MY_Y_C) return 3'd2;
        else if (dst_y < MY_Y_C) return 3'd3;
        else                     return 3'd4;
    endfunction

    logic [DATA_WIDTH-1:0] fifo_mem [NP][FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr   [NP];
    logic [PTR_W-1:0]      wr_ptr   [NP];
    logic [CNT_W-1:0]      count    [NP];
    logic [DATA_WIDTH-1:0] head_data [NP];
    logic [2:0]            head_route [NP];
    logic [NP-1:0]         head_vld;
    logic [NP-1:0]         uturn;
    logic [NP-1:0]         push;
    logic [NP-1:0]         pop;
    logic [NP-1:0]         req [NP];
    logic [NP-1:0]         out_free;
    logic [NP-1:0]         gnt_vld;
    logic [2:0]            gnt_idx [NP];
    logic [2:0]            rr_ptr  [NP];
    logic [DATA_WIDTH-1:0] do_q    [NP];
    logic [NP-1:0]         so_q;
    logic [15:0]           drop_q;
    logic [2:0]            n_drop;
    logic [16:0]           drop_sum;

    // Ready is decoded from occupancy alone, so a full FIFO refuses even when popping
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            in_ri[p] = (count[p] != FULL_CNT);
        end
    end

    assign push = in_si & in_ri;

    // Head flit of each FIFO, its route, and whether it is an illegal U-turn
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            head_vld[p]   = (count[p] != '0);
            head_data[p]  = fifo_mem[p][rd_ptr[p]];
            head_route[p] = xy_route(head_data[p][DATA_WIDTH-1 -: COORD_W],
                                     head_data[p][DATA_WIDTH-COORD_W-1 -: COORD_W]);
            uturn[p]      = head_vld[p] && (p != 4) && (head_route[p] == 3'(p));
        end
    end

    // Each non-dropped head requests exactly the output it routes to
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            for (int p = 0; p < NP; p++) begin
                req[o][p] = head_vld[p] && !uturn[p] && (head_route[p] == 3'(o));
            end
        end
    end

    // Round-robin search starting at rr_ptr; grant only when the output register can take a flit
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < NP; o++) begin
            out_free[o] = !so_q[o] || out_ro[o];
            gnt_vld[o]  = 1'b0;
            gnt_idx[o]  = 3'd0;
            for (int k = 0; k < NP; k++) begin
                idx = int'(rr_ptr[o]) + k;
                if (idx >= NP) idx = idx - NP;
                if (out_free[o] && !gnt_vld[o] && req[o][idx]) begin
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = 3'(idx);
                end
            end
        end
    end

    // An input pops when dropped or when the single output it requested granted it
    always_comb begin
        pop = uturn;
        for (int o = 0; o < NP; o++) begin
            if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
        end
    end

    // FIFO storage writes; contents are don't-care once pointers are reset
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (push[p]) fifo_mem[p][wr_ptr[p]] <= in_di[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally on power-of-two depth
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                rd_ptr[p] <= '0;
                wr_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
                if (push[p] && !pop[p])      count[p] <= count[p] + 1'b1;
                else if (!push[p] && pop[p]) count[p] <= count[p] - 1'b1;
            end
        end
    end

    // Output registers and arbiter pointers; an ungranted drained register goes invalid but keeps its data
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < NP; o++) begin
                do_q[o]   <= '0;
                rr_ptr[o] <= 3'd0;
            end
            so_q <= '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (gnt_vld[o]) begin
                    do_q[o]   <= head_data[gnt_idx[o]];
                    so_q[o]   <= 1'b1;
                    rr_ptr[o] <= (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
                end else if (out_ro[o]) begin
                    so_q[o] <= 1'b0;
                end
            end
        end
    end

    // Several links can drop in the same cycle, so add the number of drops
    always_comb begin
        n_drop = 3'd0;
        for (int p = 0; p < NP; p++) begin
            n_drop = n_drop + {2'b00, uturn[p]};
        end
        drop_sum = {1'b0, drop_q} + {14'd0, n_drop};
    end

    // Saturating drop counter
    always_ff @(posedge clk) begin
        if (reset)            drop_q <= '0;
        else if (drop_sum[16]) drop_q <= 16'hFFFF;
        else                  drop_q <= drop_sum[15:0];
    end

    assign out_so     = so_q;
    assign drop_count = drop_q;

    for (genvar g = 0; g < NP; g++) begin : g_out
        assign out_do[g*DATA_WIDTH +: DATA_WIDTH] = do_q[g];
    end

endmodule

// File: tb/tb_mesh_router_xy.sv
// Directed testbench for mesh_router_xy at node (2,2) with 16-bit flits:
// flit = {dst_x[3:0], dst_y[3:0], payload[7:0]}. Inputs change and outputs
// are sampled on the falling edge.
module tb_mesh_router_xy;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    in_si;
    logic [5*DW-1:0] in_di;
    logic [4:0]    in_ri;
    logic [4:0]    out_so;
    logic [4:0]    out_ro;
    logic [5*DW-1:0] out_do;
    logic [15:0]   drop_count;

    int checks = 0;
    int errors = 0;

    mesh_router_xy #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(4),
        .COORD_W(4),
        .MY_X(2),
        .MY_Y(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_si(in_si),
        .in_di(in_di),
        .in_ri(in_ri),
        .out_so(out_so),
        .out_ro(out_ro),
        .out_do(out_do),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk(input logic [3:0] dx, input logic [3:0] dy,
                                         input logic [7:0] pl);
        return {dx, dy, pl};
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        in_si  = 5'h1F;
        out_ro = 5'h1F;
        for (int p = 0; p < 5; p++) in_di[p*DW +: DW] = mk(4'd3, 4'd2, 8'(p));
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (in_ri !== 5'h1F) begin errors++; $display("FAIL reset_in_ri: got %h expected 1f", in_ri); end
            checks++;
            if (out_so !== 5'h00) begin errors++; $display("FAIL reset_out_so: got %h expected 00", out_so); end
            checks++;
            if (out_do !== '0) begin errors++; $display("FAIL reset_out_do: got %h expected 0", out_do); end
            checks++;
            if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop: got %h expected 0", drop_count); end
        end
        reset = 1'b0;
        in_si = 5'h00;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (out_so !== 5'h00) begin errors++; $display("FAIL reset_release_quiet: got %h expected 00", out_so); end
        end
    endtask

    task automatic test_routing;
        logic [3:0] dxs [5] = '{4'd3, 4'd1, 4'd2, 4'd2, 4'd2};
        logic [3:0] dys [5] = '{4'd2, 4'd2, 4'd3, 4'd1, 4'd2};
        int         exp_port [5] = '{1, 0, 2, 3, 4};
        logic [DW-1:0] f;
        logic [4:0]    one_hot;
        for (int i = 0; i < 5; i++) begin
            f = mk(dxs[i], dys[i], 8'h50 + 8'(i));
            one_hot = 5'b00001 << exp_port[i];
            in_di[4*DW +: DW] = f;
            in_si = 5'b10000;
            tick();
            in_si = 5'b00000;
            checks++;
            if (out_so !== 5'h00) begin errors++; $display("FAIL route_latency[%0d]: out_so %h expected 00", i, out_so); end
            tick();
            checks++;
            if (out_so !== one_hot) begin errors++; $display("FAIL route_port[%0d]: out_so %h expected %h", i, out_so, one_hot); end
            checks++;
            if (out_do[exp_port[i]*DW +: DW] !== f) begin
                errors++;
                $display("FAIL route_data[%0d]: got %h expected %h", i, out_do[exp_port[i]*DW +: DW], f);
            end
            tick();
            checks++;
            if (out_so !== 5'h00) begin errors++; $display("FAIL route_drain[%0d]: out_so %h expected 00", i, out_so); end
        end
    endtask

    task automatic test_round_robin;
        int src [4] = '{0, 2, 3, 4};
        int n;
        for (int j = 0; j < 4; j++) in_di[src[j]*DW +: DW] = mk(4'd3, 4'd2, 8'hA0 + 8'(src[j]));
        out_ro = 5'h1F;
        in_si  = 5'b11101;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (out_so !== 5'b00010) begin errors++; $display("FAIL rr_valid[%0d]: out_so %h expected 02", i, out_so); end
            checks++;
            if (out_do[DW +: DW] !== mk(4'd3, 4'd2, 8'hA0 + 8'(src[i%4]))) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %h expected %h", i, out_do[DW +: DW],
                         mk(4'd3, 4'd2, 8'hA0 + 8'(src[i%4])));
            end
        end
        in_si = 5'h00;
        n = 0;
        while (out_so !== 5'h00 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (out_so !== 5'h00) begin errors++; $display("FAIL rr_drain: out_so %h expected 00 after %0d cycles", out_so, n); end
    endtask

    task automatic test_backpressure;
        int  acc;
        logic accept;
        acc    = 0;
        out_ro = 5'b11101;
        in_si  = 5'b00001;
        for (int c = 0; c < 8; c++) begin
            in_di[0 +: DW] = mk(4'd3, 4'd2, 8'h10 + 8'(acc));
            accept = in_ri[0];
            tick();
            if (accept) acc++;
        end
        checks++;
        if (acc != 5) begin errors++; $display("FAIL bp_accepted: got %0d expected 5", acc); end
        checks++;
        if (in_ri[0] !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", in_ri[0]); end
        checks++;
        if (out_so[1] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", out_so[1]); end
        checks++;
        if (out_do[DW +: DW] !== mk(4'd3, 4'd2, 8'h10)) begin
            errors++; $display("FAIL bp_hold_data: got %h expected %h", out_do[DW +: DW], mk(4'd3, 4'd2, 8'h10));
        end
        in_si  = 5'h00;
        out_ro = 5'h1F;
        for (int i = 1; i < 5; i++) begin
            tick();
            checks++;
            if (out_so[1] !== 1'b1) begin errors++; $display("FAIL bp_release_valid[%0d]: got %b expected 1", i, out_so[1]); end
            checks++;
            if (out_do[DW +: DW] !== mk(4'd3, 4'd2, 8'h10 + 8'(i))) begin
                errors++;
                $display("FAIL bp_release_order[%0d]: got %h expected %h", i, out_do[DW +: DW], mk(4'd3, 4'd2, 8'h10 + 8'(i)));
            end
        end
        tick();
        checks++;
        if (out_so !== 5'h00) begin errors++; $display("FAIL bp_empty: out_so %h expected 00", out_so); end
        checks++;
        if (in_ri !== 5'h1F) begin errors++; $display("FAIL bp_ready_back: got %h expected 1f", in_ri); end
    endtask

    task automatic test_uturn;
        in_di[1*DW +: DW] = mk(4'd3, 4'd2, 8'hEE);
        in_si = 5'b00010;
        tick();
        in_si = 5'b00000;
        tick();
        checks++;
        if (drop_count !== 16'd1) begin errors++; $display("FAIL uturn_count: got %0d expected 1", drop_count); end
        checks++;
        if (out_so !== 5'h00) begin errors++; $display("FAIL uturn_no_out: out_so %h expected 00", out_so); end
        tick();
        checks++;
        if (out_so !== 5'h00 || drop_count !== 16'd1) begin
            errors++; $display("FAIL uturn_settle: out_so %h drop %0d expected 00 / 1", out_so, drop_count);
        end
        in_di[0*DW +: DW] = mk(4'd1, 4'd2, 8'h01);
        in_di[1*DW +: DW] = mk(4'd3, 4'd2, 8'h02);
        in_di[2*DW +: DW] = mk(4'd2, 4'd3, 8'h03);
        in_di[3*DW +: DW] = mk(4'd2, 4'd1, 8'h04);
        in_si = 5'b01111;
        for (int k = 1; k <= 16390; k++) begin
            tick();
            if (k == 2) begin
                checks++;
                if (drop_count !== 16'd5) begin errors++; $display("FAIL drop_multi: got %0d expected 5", drop_count); end
            end
            if (k == 16384) begin
                checks++;
                if (drop_count !== 16'd65533) begin errors++; $display("FAIL drop_near_sat: got %0d expected 65533", drop_count); end
            end
            if (k == 16385) begin
                checks++;
                if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL drop_sat: got %h expected ffff", drop_count); end
            end
        end
        checks++;
        if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL drop_sat_hold: got %h expected ffff", drop_count); end
        checks++;
        if (out_so !== 5'h00) begin errors++; $display("FAIL drop_no_out: out_so %h expected 00", out_so); end
        in_si = 5'h00;
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        out_ro = 5'b11101;
        in_di[0 +: DW] = mk(4'd3, 4'd2, 8'h77);
        in_si = 5'b00001;
        repeat (3) tick();
        checks++;
        if (out_so[1] !== 1'b1) begin errors++; $display("FAIL mid_precond: out_so %h expected E valid", out_so); end
        reset = 1'b1;
        tick();
        checks++;
        if (out_so !== 5'h00) begin errors++; $display("FAIL mid_out_so: got %h expected 00", out_so); end
        checks++;
        if (in_ri !== 5'h1F) begin errors++; $display("FAIL mid_in_ri: got %h expected 1f", in_ri); end
        checks++;
        if (drop_count !== 16'h0 || out_do !== '0) begin
            errors++; $display("FAIL mid_clear: drop %h out_do %h expected 0 / 0", drop_count, out_do);
        end
        reset  = 1'b0;
        in_si  = 5'h00;
        out_ro = 5'h1F;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_so !== 5'h00) begin errors++; $display("FAIL mid_stale[%0d]: out_so %h expected 00", c, out_so); end
        end
    endtask

    initial begin
        reset  = 1'b1;
        in_si  = 5'h00;
        in_di  = '0;
        out_ro = 5'h1F;
        test_reset();
        test_routing();
        test_round_robin();
        test_backpressure();
        test_uturn();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
